// File: rtl/lcd_bus_arbiter.sv
// Purpose: single owner of an HD44780-style character LCD bus; runs the power-on
//          init sequence, then round-robins writes from two requesters onto the bus.
// Latency: grant one cycle after req in idle; write = 2*PHASE_CYC + hold + 1 (ack) cycles.
// Backpressure: req is held until its one-cycle ack; at most one write in flight,
//               and one forced idle cycle follows every write.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req0/cmd0/ack0  requester 0: request, {rs,data}, completion pulse
//   req1/cmd1/ack1  requester 1: request, {rs,data}, completion pulse
//   init_done       set after the last init write, cleared only by reset
//   busy            high whenever the sequencer is not idle
//   grant_id        requester currently or most recently served
//   lcd_rs/rw/e     LCD control pins (rw tied low, write only)
//   lcd_data        LCD data bus
module lcd_bus_arbiter #(
  parameter int unsigned PHASE_CYC     = 50_000,
  parameter int unsigned INIT_WAIT_CYC = 1_000_000,
  parameter int unsigned CLEAR_CYC     = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [8:0] cmd0,
  output logic       ack0,
  input  logic       req1,
  input  logic [8:0] cmd1,
  output logic       ack1,
  output logic       init_done,
  output logic       busy,
  output logic       grant_id,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE,
    S_IDLE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic [31:0] hold_len;
  logic [1:0]  init_idx;
  logic [1:0]  init_idx_nxt;
  logic        init_done_nxt;
  logic        grant_nxt;
  logic        pick;
  logic        load;
  logic [8:0]  load_cmd;

  // Power-on init commands, all with rs=0: function set 8-bit/2-line,
  // display on, entry mode increment, clear display.
  function automatic logic [8:0] init_cmd(input logic [1:0] idx);
    logic [8:0] c;
    case (idx)
      2'd0:    c = 9'h038;
      2'd1:    c = 9'h00C;
      2'd2:    c = 9'h006;
      default: c = 9'h001;
    endcase
    return c;
  endfunction

  // Clear (0x01) and home (0x02) take far longer inside the LCD controller,
  // so their hold phase is stretched. The bus registers already hold the
  // command being written, so they select the hold length directly.
  assign hold_len = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ?
                    CLEAR_CYC : PHASE_CYC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PWR_WAIT;
      cnt       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      grant_id  <= 1'b1;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_idx  <= init_idx_nxt;
      init_done <= init_done_nxt;
      grant_id  <= grant_nxt;
      // rs/data only change on entry to S_SETUP and otherwise hold.
      if (load) begin
        lcd_rs   <= load_cmd[8];
        lcd_data <= load_cmd[7:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 32'd1;
    init_idx_nxt  = init_idx;
    init_done_nxt = init_done;
    grant_nxt     = grant_id;
    pick          = 1'b0;
    load          = 1'b0;
    load_cmd      = '0;

    case (state)
      S_PWR_WAIT: begin
        if (cnt == INIT_WAIT_CYC - 1) begin
          state_nxt    = S_SETUP;
          cnt_nxt      = '0;
          init_idx_nxt = 2'd0;
          load         = 1'b1;
          load_cmd     = init_cmd(2'd0);
        end
      end

      S_SETUP: begin
        if (cnt == PHASE_CYC - 1) begin
          state_nxt = S_PULSE;
          cnt_nxt   = '0;
        end
      end

      S_PULSE: begin
        if (cnt == PHASE_CYC - 1) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end

      S_HOLD: begin
        if (cnt == hold_len - 32'd1) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end
      end

      S_DONE: begin
        cnt_nxt = '0;
        if (!init_done) begin
          if (init_idx == 2'd3) begin
            init_done_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end else begin
            init_idx_nxt = init_idx + 2'd1;
            load         = 1'b1;
            load_cmd     = init_cmd(init_idx + 2'd1);
            state_nxt    = S_SETUP;
          end
        end else begin
          // No grant here: a req still high during its ack cycle is only
          // seen again after a full idle cycle, so it cannot be re-served.
          state_nxt = S_IDLE;
        end
      end

      S_IDLE: begin
        cnt_nxt = '0;
        if (req0 || req1) begin
          // grant_id doubles as the last-served pointer: on a tie the
          // other requester wins.
          pick      = (req0 && req1) ? ~grant_id : req1;
          grant_nxt = pick;
          load      = 1'b1;
          load_cmd  = pick ? cmd1 : cmd0;
          state_nxt = S_SETUP;
        end
      end

      default: begin
        state_nxt = S_PWR_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The init writes run with init_done low, so a DONE cycle with init_done
  // high always belongs to a requester write.
  assign ack0   = (state == S_DONE) && init_done && !grant_id;
  assign ack1   = (state == S_DONE) && init_done &&  grant_id;
  assign busy   = (state != S_IDLE);
  assign lcd_e  = (state == S_PULSE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: each scenario lists requester transactions, a
// transaction-level model turns them into an expected per-cycle bus trace,
// and the DUT is compared against that trace every cycle.
module tb_lcd_bus_arbiter;

  localparam int P    = 4;
  localparam int IW   = 20;
  localparam int CL   = 10;
  localparam int INF  = 1 << 30;
  localparam int MAXI = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [8:0] cmd0 = '0;
  logic [8:0] cmd1 = '0;
  logic       ack0, ack1, init_done, busy, grant_id;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(.PHASE_CYC(P), .INIT_WAIT_CYC(IW), .CLEAR_CYC(CL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .ack1(ack1),
    .init_done(init_done), .busy(busy), .grant_id(grant_id),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  typedef struct packed {
    logic       init_done;
    logic       grant;
    logic       ack1;
    logic       ack0;
    logic       busy;
    logic       rw;
    logic       e;
    logic       rs;
    logic [7:0] d;
  } obs_t;

  int errors = 0;
  int checks = 0;

  // Expected observation for every sample; index 0 is the sample right after
  // the reset edge.
  obs_t exp_q[$];
  logic       m_rs, m_done, m_grant;
  logic [7:0] m_d;

  // Requester transactions: it_gap[i][0] is the absolute raise sample, later
  // gaps are relative to the previous ack of that requester. it_drop < 0 keeps
  // req up until ack, otherwise req drops that many cycles after grant.
  int         it_n [2];
  logic [8:0] it_cmd [2][MAXI];
  int         it_gap [2][MAXI];
  int         it_drop [2][MAXI];
  int         it_r [2][MAXI];
  int         it_g [2][MAXI];
  int         it_a [2][MAXI];
  int         it_e [2][MAXI];

  function automatic void clear_items();
    it_n[0] = 0;
    it_n[1] = 0;
  endfunction

  function automatic void model_reset();
    m_rs = 1'b0; m_d = 8'h00; m_grant = 1'b1; m_done = 1'b0;
  endfunction

  function automatic void push(logic b, logic e, logic a0, logic a1);
    obs_t o;
    o.init_done = m_done; o.grant = m_grant; o.ack1 = a1; o.ack0 = a0;
    o.busy = b; o.rw = 1'b0; o.e = e; o.rs = m_rs; o.d = m_d;
    exp_q.push_back(o);
  endfunction

  // One bus write: setup, strobe, hold, then the one completion cycle.
  function automatic void push_write(logic [8:0] c, int src);
    int h;
    h = (c[8] == 1'b0 && (c[7:0] == 8'h01 || c[7:0] == 8'h02)) ? CL : P;
    m_rs = c[8];
    m_d  = c[7:0];
    for (int k = 0; k < P; k++) push(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < P; k++) push(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < h; k++) push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, src == 0, src == 1);
  endfunction

  function automatic void push_init();
    logic [8:0] seq [4];
    seq[0] = 9'h038; seq[1] = 9'h00C; seq[2] = 9'h006; seq[3] = 9'h001;
    for (int k = 0; k < IW; k++) push(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push_write(seq[k], 2);
    m_done = 1'b1;
  endfunction

  // Serves the listed transactions one at a time from the current idle point:
  // earliest pending request wins, a tie goes to whoever was not served last.
  function automatic void schedule();
    int   t, g, a;
    int   idx [2];
    int   rr [2];
    logic p0, p1, pk;
    t = exp_q.size();
    for (int i = 0; i < 2; i++) begin
      idx[i] = 0;
      rr[i]  = (it_n[i] > 0) ? it_gap[i][0] : INF;
    end
    while (idx[0] < it_n[0] || idx[1] < it_n[1]) begin
      g = (rr[0] < rr[1]) ? rr[0] : rr[1];
      if (g < t) g = t;
      while (exp_q.size() <= g) push(1'b0, 1'b0, 1'b0, 1'b0);
      p0 = (rr[0] <= g);
      p1 = (rr[1] <= g);
      pk = (p0 && p1) ? ~m_grant : p1;
      m_grant = pk;
      it_r[pk][idx[pk]] = rr[pk];
      it_g[pk][idx[pk]] = g;
      push_write(it_cmd[pk][idx[pk]], int'(pk));
      a = exp_q.size() - 1;
      it_a[pk][idx[pk]] = a;
      it_e[pk][idx[pk]] = (it_drop[pk][idx[pk]] < 0) ? a : g + it_drop[pk][idx[pk]];
      idx[pk]++;
      rr[pk] = (idx[pk] < it_n[pk]) ? a + it_gap[pk][idx[pk]] : INF;
      t = a + 1;
    end
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.init_done = init_done; o.grant = grant_id; o.ack1 = ack1; o.ack0 = ack0;
    o.busy = busy; o.rw = lcd_rw; o.e = lcd_e; o.rs = lcd_rs; o.d = lcd_data;
    return o;
  endfunction

  // Requester inputs for the cycle of sample s; cmd is junk outside the
  // raise..grant window so any use of a stale cmd shows up on the bus.
  task automatic drive(input int s);
    logic       r [2];
    logic [8:0] c [2];
    for (int i = 0; i < 2; i++) begin
      r[i] = 1'b0;
      c[i] = 9'($urandom);
      for (int j = 0; j < it_n[i]; j++) begin
        if (s >= it_r[i][j] && s <= it_e[i][j]) r[i] = 1'b1;
        if (s >= it_r[i][j] && s <= it_g[i][j]) c[i] = it_cmd[i][j];
      end
    end
    req0 = r[0]; cmd0 = c[0];
    req1 = r[1]; cmd1 = c[1];
  endtask

  task automatic start_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, ro;
    exp_q.delete(); model_reset(); push(1'b1, 1'b0, 1'b0, 1'b0);
    ro  = exp_q[0];
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0 = 1'b1; cmd0 = 9'($urandom); req1 = k[0]; cmd1 = 9'($urandom);
      @(posedge clk); #1;
      o = cur_obs();
      checks++;
      if (o !== ro) begin
        errors++; $display("FAIL reset_state k=%0d got=%h exp=%h", k, o, ro);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_init();
    obs_t o;
    int e_hi = 0, done_at = -1, idle_at = -1;
    clear_items(); exp_q.delete(); model_reset(); push_init(); schedule();
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL init_trace s=%0d got=%h exp=%h", s, o, exp_q[s]);
      end
      if (o.e) e_hi++;
      if (o.init_done && done_at < 0) done_at = s;
      if (!o.busy && idle_at < 0) idle_at = s;
      drive(s); @(posedge clk); #1;
    end
    checks++;
    if (e_hi !== 16) begin errors++; $display("FAIL init_e_cycles got=%0d exp=16", e_hi); end
    checks++;
    if (done_at !== 78) begin errors++; $display("FAIL init_done_at got=%0d exp=78", done_at); end
    checks++;
    if (idle_at !== 78) begin errors++; $display("FAIL busy_fall_at got=%0d exp=78", idle_at); end
  endtask

  task automatic test_single();
    obs_t o;
    int a0_at = -1, n0 = 0, n1 = 0;
    clear_items();
    it_n[0] = 1; it_cmd[0][0] = 9'h141; it_gap[0][0] = 78; it_drop[0][0] = -1;
    exp_q.delete(); model_reset(); push_init(); schedule();
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL single_trace s=%0d got=%h exp=%h", s, o, exp_q[s]);
      end
      if (o.ack0) begin n0++; if (a0_at < 0) a0_at = s; end
      if (o.ack1) n1++;
      drive(s); @(posedge clk); #1;
    end
    checks++;
    if (a0_at !== 91) begin errors++; $display("FAIL single_ack0_at got=%0d exp=91", a0_at); end
    checks++;
    if (n0 !== 1 || n1 !== 0) begin
      errors++; $display("FAIL single_ack_count got=%0d/%0d exp=1/0", n0, n1);
    end
  endtask

  task automatic test_both();
    obs_t o;
    int a0_at = -1, a1_at = -1;
    clear_items();
    it_n[0] = 1; it_cmd[0][0] = 9'h130; it_gap[0][0] = 80; it_drop[0][0] = -1;
    it_n[1] = 1; it_cmd[1][0] = 9'h142; it_gap[1][0] = 80; it_drop[1][0] = -1;
    exp_q.delete(); model_reset(); push_init(); schedule();
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL both_trace s=%0d got=%h exp=%h", s, o, exp_q[s]);
      end
      if (o.ack0 && a0_at < 0) a0_at = s;
      if (o.ack1 && a1_at < 0) a1_at = s;
      if (s == 81) begin
        checks++;
        if (o.grant !== 1'b0) begin errors++; $display("FAIL both_first_grant got=%0d exp=0", o.grant); end
      end
      if (s == 95) begin
        checks++;
        if (o.grant !== 1'b1) begin errors++; $display("FAIL both_second_grant got=%0d exp=1", o.grant); end
      end
      drive(s); @(posedge clk); #1;
    end
    checks++;
    if (a0_at !== 93 || a1_at !== 107) begin
      errors++; $display("FAIL both_ack_times got=%0d/%0d exp=93/107", a0_at, a1_at);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int n1 = 0;
    int at [3];
    logic prev = 1'b0;
    clear_items();
    it_n[1] = 3;
    for (int j = 0; j < 3; j++) begin
      it_cmd[1][j] = 9'h153 + 9'(j); it_gap[1][j] = (j == 0) ? 78 : 0; it_drop[1][j] = -1;
    end
    exp_q.delete(); model_reset(); push_init(); schedule();
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL b2b_trace s=%0d got=%h exp=%h", s, o, exp_q[s]);
      end
      if (o.ack1) begin
        if (n1 < 3) at[n1] = s;
        n1++;
        checks++;
        if (prev) begin errors++; $display("FAIL b2b_double_ack s=%0d got=1 exp=0", s); end
      end
      prev = o.ack1;
      drive(s); @(posedge clk); #1;
    end
    checks++;
    if (n1 !== 3) begin
      errors++; $display("FAIL b2b_ack_count got=%0d exp=3", n1);
    end else begin
      checks++;
      if (at[0] !== 91 || at[1] !== 105 || at[2] !== 119) begin
        errors++; $display("FAIL b2b_ack_times got=%0d,%0d,%0d exp=91,105,119", at[0], at[1], at[2]);
      end
    end
  endtask

  task automatic test_clear_early();
    obs_t o;
    int a0_at = -1;
    clear_items();
    it_n[0] = 1; it_cmd[0][0] = 9'h001; it_gap[0][0] = 5; it_drop[0][0] = -1;
    exp_q.delete(); model_reset(); push_init(); schedule();
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL clear_trace s=%0d got=%h exp=%h", s, o, exp_q[s]);
      end
      if (o.ack0 && a0_at < 0) a0_at = s;
      drive(s); @(posedge clk); #1;
    end
    checks++;
    if (a0_at !== 97) begin errors++; $display("FAIL clear_ack0_at got=%0d exp=97", a0_at); end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    int x, n0 = 0;
    clear_items();
    it_n[0] = 1; it_cmd[0][0] = 9'h1AA; it_gap[0][0] = 78; it_drop[0][0] = -1;
    exp_q.delete(); model_reset(); push_init(); schedule();
    x = it_g[0][0] + P + 2;               // sample inside the strobe phase
    while (exp_q.size() > x + 1) void'(exp_q.pop_back());
    it_e[0][0] = x;
    model_reset(); push_init();
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, 1'b0);
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL rstmid_trace s=%0d got=%h exp=%h", s, o, exp_q[s]);
      end
      if (s == x) begin
        checks++;
        if (o.e !== 1'b1) begin errors++; $display("FAIL rstmid_in_pulse got=%0d exp=1", o.e); end
      end
      if (s == x + 1) begin
        checks++;
        if (o.e !== 1'b0 || o.ack0 !== 1'b0 || o.init_done !== 1'b0) begin
          errors++; $display("FAIL rstmid_after e/ack0/init_done got=%0d%0d%0d exp=000", o.e, o.ack0, o.init_done);
        end
      end
      if (o.ack0) n0++;
      drive(s);
      rst = (s == x);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    checks++;
    if (n0 !== 0) begin errors++; $display("FAIL rstmid_ack_count got=%0d exp=0", n0); end
  endtask

  task automatic test_random(input int round);
    obs_t o;
    int n [2];
    clear_items();
    for (int i = 0; i < 2; i++) begin
      it_n[i] = $urandom_range(1, 4);
      for (int j = 0; j < it_n[i]; j++) begin
        it_cmd[i][j] = 9'($urandom);
        if ($urandom_range(0, 3) == 0) it_cmd[i][j] = ($urandom_range(0, 1) != 0) ? 9'h001 : 9'h002;
        it_gap[i][j]  = (j == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 15));
        it_drop[i][j] = ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(0, 8));
      end
    end
    exp_q.delete(); model_reset(); push_init(); schedule();
    n[0] = 0; n[1] = 0;
    start_reset();
    for (int s = 0; s < exp_q.size(); s++) begin
      o = cur_obs();
      checks++;
      if (o !== exp_q[s]) begin
        errors++; $display("FAIL rand%0d_trace s=%0d got=%h exp=%h", round, s, o, exp_q[s]);
      end
      if (o.ack0) n[0]++;
      if (o.ack1) n[1]++;
      drive(s); @(posedge clk); #1;
    end
    checks++;
    if (n[0] !== it_n[0] || n[1] !== it_n[1]) begin
      errors++; $display("FAIL rand%0d_ack_count got=%0d/%0d exp=%0d/%0d", round, n[0], n[1], it_n[0], it_n[1]);
    end
  endtask

  initial begin
    clear_items();
    test_reset();
    test_init();
    test_single();
    test_both();
    test_back_to_back();
    test_clear_early();
    test_reset_mid_write();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
